// File: rtl/baseball_pkg.sv
// Shared types and helpers for the number-baseball history block.
// Score width, index width and readout field encodings live here.
package baseball_pkg;

    typedef logic [3:0] bcd_t;

    // Bits needed to hold a score of 0..digits.
    function automatic int score_w(input int digits);
        return $clog2(digits + 1);
    endfunction

    // Select width for n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Readout field code that selects the ball score.
    function automatic int field_ball(input int digits);
        return digits;
    endfunction

    // Readout field code that selects the strike score.
    function automatic int field_strike(input int digits);
        return digits + 1;
    endfunction

endpackage

// File: rtl/guess_lane.sv
// One player's shift history of guesses with scores, plus turn count.
// Entry 0 is the newest; the oldest entry falls off on each accept.
module guess_lane
    import baseball_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DIGITS = 3,
    parameter int SW     = 2,
    parameter int EW     = 2,
    parameter int FW     = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                accept,
    input  logic [4*DIGITS-1:0] guess,
    input  logic [SW-1:0]       strike,
    input  logic [SW-1:0]       ball,
    input  logic [EW-1:0]       rd_entry,
    input  logic [FW-1:0]       rd_field,
    output logic [3:0]          rd_data,
    output logic                rd_valid,
    output logic [7:0]          turns
);

    typedef struct packed {
        logic [4*DIGITS-1:0] guess;
        logic [SW-1:0]       ball;
        logic [SW-1:0]       strike;
        logic                valid;
    } entry_t;

    entry_t     hist [DEPTH];
    logic [7:0] turns_q;
    entry_t     sel;
    bcd_t       dig;

    assign turns = turns_q;

    // Shift a new entry in on accept; clear on reset or new game.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
            turns_q <= '0;
        end else if (clr) begin
            for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
            turns_q <= '0;
        end else if (accept) begin
            hist[0] <= '{guess: guess, ball: ball,
                         strike: strike, valid: 1'b1};
            for (int k = 1; k < DEPTH; k++) hist[k] <= hist[k-1];
            turns_q <= turns_q + 8'd1;
        end
    end

    // Pick one nibble of the selected entry; empty entries read as zero.
    always_comb begin
        sel      = '0;
        dig      = '0;
        rd_data  = '0;
        rd_valid = 1'b0;
        if (int'(rd_entry) < DEPTH) begin
            sel      = hist[rd_entry];
            rd_valid = sel.valid;
        end
        if (sel.valid) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (int'(rd_field) == i) begin
                    dig     = sel.guess[4*(DIGITS-1-i) +: 4];
                    rd_data = dig;
                end
            end
            if (int'(rd_field) == field_ball(DIGITS))
                rd_data = 4'(sel.ball);
            if (int'(rd_field) == field_strike(DIGITS))
                rd_data = 4'(sel.strike);
        end
    end

endmodule

// File: rtl/guess_history.sv
// Per-player guess history with win/draw latching and display readout.
// Define GUESS_HISTORY_TURN_EN to enforce round-robin turn order.
module guess_history
    import baseball_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int DEPTH       = 4,
    parameter int DIGITS      = 3,
    parameter int MAX_TURNS   = 10
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        clr,
    input  logic                                        on_game,
    input  logic [NUM_PLAYERS-1:0]                      push,
    input  logic [4*DIGITS-1:0]                         guess,
    input  logic [NUM_PLAYERS*score_w(DIGITS)-1:0]      strike,
    input  logic [NUM_PLAYERS*score_w(DIGITS)-1:0]      ball,
    input  logic [idx_w(NUM_PLAYERS)-1:0]               rd_player,
    input  logic [idx_w(DEPTH)-1:0]                     rd_entry,
    input  logic [$clog2(DIGITS+2)-1:0]                 rd_field,
    output logic [3:0]                                  rd_data,
    output logic                                        rd_valid,
    output logic [NUM_PLAYERS*8-1:0]                    turns,
    output logic                                        win,
    output logic [idx_w(NUM_PLAYERS)-1:0]               winner,
    output logic                                        draw,
    output logic [idx_w(NUM_PLAYERS)-1:0]               turn
);

    localparam int SW = score_w(DIGITS);
    localparam int PW = idx_w(NUM_PLAYERS);
    localparam int EW = idx_w(DEPTH);
    localparam int FW = $clog2(DIGITS + 2);

    logic [NUM_PLAYERS-1:0] acc;
    logic [7:0]             lane_turns [NUM_PLAYERS];
    logic [3:0]             lane_data  [NUM_PLAYERS];
    logic                   lane_valid [NUM_PLAYERS];
    logic                   win_q;
    logic                   draw_q;
    logic [PW-1:0]          winner_q;
    logic                   win_set;
    logic [PW-1:0]          win_idx;
    logic                   all_max;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_lane
        guess_lane #(
            .DEPTH  (DEPTH),
            .DIGITS (DIGITS),
            .SW     (SW),
            .EW     (EW),
            .FW     (FW)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .accept   (acc[p]),
            .guess    (guess),
            .strike   (strike[p*SW +: SW]),
            .ball     (ball[p*SW +: SW]),
            .rd_entry (rd_entry),
            .rd_field (rd_field),
            .rd_data  (lane_data[p]),
            .rd_valid (lane_valid[p]),
            .turns    (lane_turns[p])
        );
        assign turns[p*8 +: 8] = lane_turns[p];
    end

`ifdef GUESS_HISTORY_TURN_EN
    logic [PW-1:0] turn_q;
    logic [PW-1:0] turn_nxt;
    logic          found;
    int            cand;

    assign turn = turn_q;
`else
    assign turn = '0;
`endif

    // Gate each push by game state, turn budget and turn order.
    always_comb begin
        acc = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            acc[p] = push[p] & on_game & ~win_q & ~draw_q
                   & (lane_turns[p] < 8'(MAX_TURNS));
`ifdef GUESS_HISTORY_TURN_EN
            if (int'(turn_q) != p) acc[p] = 1'b0;
`endif
        end
    end

    // Lowest accepted full-strike player wins; detect all-out draw.
    always_comb begin
        win_set = 1'b0;
        win_idx = '0;
        all_max = 1'b1;
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if (acc[p] && int'(strike[p*SW +: SW]) == DIGITS) begin
                win_set = 1'b1;
                win_idx = PW'(p);
            end
        end
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (int'(lane_turns[p]) + (acc[p] ? 1 : 0) != MAX_TURNS)
                all_max = 1'b0;
        end
    end

`ifdef GUESS_HISTORY_TURN_EN
    // Next player in rotation that still has turns left.
    always_comb begin
        turn_nxt = turn_q;
        found    = 1'b0;
        cand     = 0;
        if (|acc) begin
            turn_nxt = PW'((int'(turn_q) + 1) % NUM_PLAYERS);
            for (int k = 1; k <= NUM_PLAYERS; k++) begin
                cand = (int'(turn_q) + k) % NUM_PLAYERS;
                if (!found &&
                    int'(lane_turns[cand]) + (acc[cand] ? 1 : 0)
                        < MAX_TURNS) begin
                    turn_nxt = PW'(cand);
                    found    = 1'b1;
                end
            end
        end
    end
`endif

    // Sticky game outcome and turn pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q    <= 1'b0;
            draw_q   <= 1'b0;
            winner_q <= '0;
`ifdef GUESS_HISTORY_TURN_EN
            turn_q   <= '0;
`endif
        end else if (clr) begin
            win_q    <= 1'b0;
            draw_q   <= 1'b0;
            winner_q <= '0;
`ifdef GUESS_HISTORY_TURN_EN
            turn_q   <= '0;
`endif
        end else begin
            if (win_set) begin
                win_q    <= 1'b1;
                winner_q <= win_idx;
            end else if (!win_q && all_max) begin
                draw_q <= 1'b1;
            end
`ifdef GUESS_HISTORY_TURN_EN
            turn_q <= turn_nxt;
`endif
        end
    end

    assign win    = win_q;
    assign draw   = draw_q;
    assign winner = winner_q;

    // Route the selected player's nibble to the renderer.
    always_comb begin
        rd_data  = '0;
        rd_valid = 1'b0;
        if (int'(rd_player) < NUM_PLAYERS) begin
            rd_data  = lane_data[rd_player];
            rd_valid = lane_valid[rd_player];
        end
    end

endmodule

// File: tb/tb_guess_history.sv
// Directed bench for guess_history with default parameters.
// Turn-order checks apply when GUESS_HISTORY_TURN_EN is defined.
module tb_guess_history;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        on_game;
    logic [1:0]  push;
    logic [11:0] guess;
    logic [3:0]  strike;
    logic [3:0]  ball;
    logic [0:0]  rd_player;
    logic [1:0]  rd_entry;
    logic [2:0]  rd_field;
    logic [3:0]  rd_data;
    logic        rd_valid;
    logic [15:0] turns;
    logic        win;
    logic [0:0]  winner;
    logic        draw;
    logic [0:0]  turn;

    int errors = 0;
    int checks = 0;

    guess_history dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .on_game   (on_game),
        .push      (push),
        .guess     (guess),
        .strike    (strike),
        .ball      (ball),
        .rd_player (rd_player),
        .rd_entry  (rd_entry),
        .rd_field  (rd_field),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .turns     (turns),
        .win       (win),
        .winner    (winner),
        .draw      (draw),
        .turn      (turn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle push pulse; strike/ball packed {p1,p0}.
    task automatic psh(input logic [1:0] m, input logic [11:0] g,
                       input logic [3:0] s, input logic [3:0] b);
        @(negedge clk);
        push   = m;
        guess  = g;
        strike = s;
        ball   = b;
        @(negedge clk);
        push = '0;
    endtask

    task automatic rd(input logic [0:0] p, input logic [1:0] e,
                      input logic [2:0] f);
        rd_player = p;
        rd_entry  = e;
        rd_field  = f;
        #1;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; on_game = 1'b0; push = '0;
        guess = '0; strike = '0; ball = '0;
        rd_player = '0; rd_entry = '0; rd_field = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        rd(0, 0, 0);
        chk("rst_data", 32'(rd_data), 0);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_win", 32'(win), 0);
        chk("rst_draw", 32'(draw), 0);
        chk("rst_turns", 32'(turns), 0);
        chk("rst_turn", 32'(turn), 0);
        on_game = 1'b1;

`ifndef GUESS_HISTORY_TURN_EN
        psh(2'b01, 12'h123, 4'b0001, 4'b0001);
        rd(0, 0, 0); chk("p0_d0", 32'(rd_data), 1);
        chk("p0_valid", 32'(rd_valid), 1);
        rd(0, 0, 1); chk("p0_d1", 32'(rd_data), 2);
        rd(0, 0, 2); chk("p0_d2", 32'(rd_data), 3);
        rd(0, 0, 3); chk("p0_ball", 32'(rd_data), 1);
        rd(0, 0, 4); chk("p0_strike", 32'(rd_data), 1);
        rd(0, 0, 5); chk("p0_badfield", 32'(rd_data), 0);
        rd(0, 1, 0); chk("p0_e1_valid", 32'(rd_valid), 0);
        chk("p0_turns", 32'(turns), 32'h0001);

        for (int i = 1; i <= 5; i++)
            psh(2'b10, 12'(i * 12'h111), 4'b0000, 4'b1000);
        rd(1, 0, 0); chk("p1_e0", 32'(rd_data), 5);
        rd(1, 1, 0); chk("p1_e1", 32'(rd_data), 4);
        rd(1, 2, 0); chk("p1_e2", 32'(rd_data), 3);
        rd(1, 3, 0); chk("p1_e3", 32'(rd_data), 2);
        chk("p1_e3_valid", 32'(rd_valid), 1);
        rd(1, 0, 3); chk("p1_ball", 32'(rd_data), 2);
        chk("p1_turns", 32'(turns), 32'h0501);

        on_game = 1'b0;
        psh(2'b01, 12'h999, 4'b0000, 4'b0000);
        chk("off_game", 32'(turns), 32'h0501);
        on_game = 1'b1;

        psh(2'b11, 12'h456, 4'b1111, 4'b0000);
        chk("win", 32'(win), 1);
        chk("winner", 32'(winner), 0);
        chk("win_nodraw", 32'(draw), 0);
        chk("win_turns", 32'(turns), 32'h0602);
        psh(2'b10, 12'h789, 4'b0000, 4'b0000);
        chk("frozen_turns", 32'(turns), 32'h0602);
        rd(1, 0, 0); chk("frozen_e0", 32'(rd_data), 4);

        @(negedge clk);
        clr = 1'b1; push = 2'b01;
        @(negedge clk);
        clr = 1'b0; push = '0;
        chk("clr_win", 32'(win), 0);
        chk("clr_turns", 32'(turns), 0);
        rd(0, 0, 0); chk("clr_valid", 32'(rd_valid), 0);

        psh(2'b10, 12'h321, 4'b1100, 4'b0000);
        chk("win_p1", 32'(winner), 1);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;

        for (int i = 1; i <= 10; i++) begin
            psh(2'b11, 12'(12'h100 + i), 4'b0000, 4'b0000);
            if (i == 9) chk("draw_early", 32'(draw), 0);
        end
        chk("draw", 32'(draw), 1);
        chk("draw_nowin", 32'(win), 0);
        chk("draw_turns", 32'(turns), 32'h0a0a);
        psh(2'b11, 12'h999, 4'b0000, 4'b0000);
        chk("draw_frozen", 32'(turns), 32'h0a0a);
        rd(1, 0, 2); chk("draw_e0", 32'(rd_data), 32'ha);
`else
        psh(2'b10, 12'h111, 4'b0000, 4'b0000);
        chk("t_ignored", 32'(turns), 0);
        chk("t_turn0", 32'(turn), 0);
        psh(2'b01, 12'h222, 4'b0000, 4'b0000);
        chk("t_accepted", 32'(turns), 32'h0001);
        chk("t_turn1", 32'(turn), 1);
        psh(2'b01, 12'h333, 4'b0000, 4'b0000);
        chk("t_wrongturn", 32'(turns), 32'h0001);
        @(negedge clk);
        clr = 1'b1; push = 2'b10;
        @(negedge clk);
        clr = 1'b0; push = '0;
        chk("t_clr_turns", 32'(turns), 0);
        chk("t_clr_turn", 32'(turn), 0);
        rd(0, 0, 0); chk("t_clr_valid", 32'(rd_valid), 0);
`endif

        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_draw", 32'(draw), 0);
        chk("async_turns", 32'(turns), 0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
